// File: rtl/word_chunk_serializer.sv
// -----------------------------------------------------------------------------
// word_chunk_serializer
//
// Accepts one IN_W-bit word per valid/ready handshake and emits it as NCHUNK
// OUT_W-bit chunks on a second valid/ready handshake. The final chunk of each
// word is flagged with out_last. The word is zero-extended at the top to a
// whole number of chunks. A new word can be accepted in the same cycle that
// the last chunk of the previous word is taken, so a steady stream of words
// leaves no idle cycles between them.
//
// Parameters
//   IN_W       input word width
//   OUT_W      output chunk width
//   MSB_FIRST  0: least-significant chunk first, 1: most-significant first
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     input word valid
//   in_ready     word accepted this cycle when in_valid is also high
//   input_data   input word, sampled only on accept
//   out_valid    output chunk valid
//   out_ready    downstream takes the chunk this cycle
//   output_data  current chunk, driven straight from a register
//   out_last     current chunk is the final chunk of its word
// -----------------------------------------------------------------------------
module word_chunk_serializer #(
    parameter int IN_W      = 23,
    parameter int OUT_W     = 5,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  input_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] output_data,
    output logic             out_last
);

    localparam int NCHUNK = (IN_W + OUT_W - 1) / OUT_W;
    localparam int PAD_W  = NCHUNK * OUT_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [PAD_W-1:0] shift_reg, shift_next;
    logic [PAD_W-1:0] padded_word;
    logic [PAD_W-1:0] load_word;
    logic             accept;
    logic             chunk_taken;

    always_comb begin
        padded_word             = '0;
        padded_word[IN_W-1:0]   = input_data;
    end

    // The shift register holds the chunks already in emission order, so the
    // outgoing chunk always sits in the bottom slot and every advance is a
    // plain right shift, whatever the chunk order.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_order
            localparam int SRC = (MSB_FIRST != 0) ? (NCHUNK - 1 - gi) : gi;
            assign load_word[gi*OUT_W +: OUT_W] = padded_word[SRC*OUT_W +: OUT_W];
        end
    endgenerate

    assign out_valid   = (state_reg == ST_SEND);
    assign out_last    = out_valid && (idx_reg == LAST_IDX);
    assign output_data = shift_reg[OUT_W-1:0];

    // Ready also opens while the last chunk is being taken; this gives
    // zero-bubble word-to-word transfer at the cost of a combinational
    // out_ready -> in_ready path.
    assign in_ready    = (state_reg == ST_IDLE) || (out_valid && out_last && out_ready);
    assign accept      = in_valid && in_ready;
    assign chunk_taken = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        if (accept) begin
            state_next = ST_SEND;
            idx_next   = '0;
            shift_next = load_word;
        end else if (chunk_taken) begin
            if (out_last) begin
                state_next = ST_IDLE;
            end else begin
                idx_next   = idx_reg + IDX_W'(1);
                shift_next = shift_reg >> OUT_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
        end
    end

endmodule

// File: tb/tb_word_chunk_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_chunk_serializer
//
// Three instances: 23/5 LSB-first, 23/5 MSB-first (sharing inputs with the
// first) and 16/4 LSB-first. Directed vectors come from a table of
// hand-computed chunks; back-to-back, backpressure and reset are hand-written
// sequences; a random valid/ready phase reassembles words against a queue.
// -----------------------------------------------------------------------------
module tb_word_chunk_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // group A: shared by dut0 (LSB first) and dut1 (MSB first)
    logic        in_valid_a, out_ready_a;
    logic [22:0] data_a;
    logic        ir0, ov0, ol0, ir1, ov1, ol1;
    logic [4:0]  od0, od1;

    // group B: dut2, 16-bit words in 4-bit chunks
    logic        in_valid_b, out_ready_b;
    logic [15:0] data_b;
    logic        ir2, ov2, ol2;
    logic [3:0]  od2;

    word_chunk_serializer #(.IN_W(23), .OUT_W(5), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(ir0),
        .input_data(data_a), .out_valid(ov0), .out_ready(out_ready_a),
        .output_data(od0), .out_last(ol0));

    word_chunk_serializer #(.IN_W(23), .OUT_W(5), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(ir1),
        .input_data(data_a), .out_valid(ov1), .out_ready(out_ready_a),
        .output_data(od1), .out_last(ol1));

    word_chunk_serializer #(.IN_W(16), .OUT_W(4), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(ir2),
        .input_data(data_b), .out_valid(ov2), .out_ready(out_ready_b),
        .output_data(od2), .out_last(ol2));

    typedef struct packed {
        logic [22:0]      word;
        logic             msb;
        logic [0:4][4:0]  exp;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_a(input logic msb, output logic ir, output logic ov,
                         output logic ol, output logic [4:0] od);
        if (msb) begin
            ir = ir1; ov = ov1; ol = ol1; od = od1;
        end else begin
            ir = ir0; ov = ov0; ol = ol0; od = od0;
        end
    endtask

    // One word with out_ready held high: ready in idle, five chunks starting
    // one cycle after accept, out_last on the fifth, then back to idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic ir, ov, ol;
        logic [4:0] od;
        @(negedge clk);
        in_valid_a = 1'b1; data_a = v.word; out_ready_a = 1'b1;
        #1;
        get_a(v.msb, ir, ov, ol, od);
        check($sformatf("vec%0d_idle_ready", idx), {31'd0, ir}, 32'd1);
        @(negedge clk);
        in_valid_a = 1'b0; data_a = 23'h2AAAAA;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            get_a(v.msb, ir, ov, ol, od);
            check($sformatf("vec%0d_chunk%0d", idx, k), {25'd0, ov, ol, od},
                  {25'd0, 1'b1, (k == 4), v.exp[k]});
        end
        @(negedge clk);
        #1;
        get_a(v.msb, ir, ov, ol, od);
        check($sformatf("vec%0d_back_idle", idx), {31'd0, ov}, 32'd0);
        $display("vec %0d: word 0x%06h msb_first=%0d sent", idx, v.word, v.msb);
    endtask

    // Random valid/ready traffic; chunks are reassembled and compared with
    // the queue of accepted words.
    task automatic rand_run(input int g, input int nwords);
        int nch, ow, ka, kb, sent, done_a, done_b, cycles;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] acc_a, acc_b, cur_d, expw;
        logic cur_v, r, stall, prev_ol, acc_now_a, acc_now_b;
        logic [4:0] prev_od;
        logic ir, ov, ol, irb, ovb, olb;
        logic [4:0] od, odb;
        nch = (g == 0) ? 5 : 4;
        ow  = (g == 0) ? 5 : 4;
        ka = 0; kb = 0; sent = 0; done_a = 0; done_b = 0; cycles = 0;
        acc_a = '0; acc_b = '0; cur_d = '0; cur_v = 1'b0; stall = 1'b0;
        prev_ol = 1'b0; prev_od = '0;
        while (done_a < nwords && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            if (!cur_v && sent < nwords && $urandom_range(0, 3) != 0) begin
                cur_v = 1'b1;
                cur_d = (g == 0) ? ($urandom & 32'h7FFFFF) : ($urandom & 32'hFFFF);
            end
            r = ($urandom_range(0, 3) != 0);
            if (g == 0) begin
                in_valid_a = cur_v; data_a = cur_d[22:0]; out_ready_a = r;
            end else begin
                in_valid_b = cur_v; data_b = cur_d[15:0]; out_ready_b = r;
            end
            #1;
            if (g == 0) begin
                ir = ir0; ov = ov0; ol = ol0; od = od0;
                irb = ir1; ovb = ov1; olb = ol1; odb = od1;
            end else begin
                ir = ir2; ov = ov2; ol = ol2; od = {1'b0, od2};
                irb = 1'b0; ovb = 1'b0; olb = 1'b0; odb = '0;
            end
            if (stall)
                check($sformatf("rand%0d_stall_hold", g), {25'd0, ov, ol, od},
                      {25'd0, 1'b1, prev_ol, prev_od});
            acc_now_a = cur_v && ir;
            acc_now_b = cur_v && irb;
            if (acc_now_a) begin qa.push_back(cur_d); sent++; end
            if (acc_now_b) qb.push_back(cur_d);
            if (acc_now_a) cur_v = 1'b0;
            if (ov && r) begin
                acc_a = acc_a | (32'(od) << (ka * ow));
                check($sformatf("rand%0d_last_flag", g), {31'd0, ol}, {31'd0, (ka == nch - 1)});
                if (ka == nch - 1) begin
                    if (qa.size() == 0) begin
                        check($sformatf("rand%0d_underflow", g), 32'd1, 32'd0);
                    end else begin
                        expw = qa.pop_front();
                        check($sformatf("rand%0d_word", g), acc_a, expw);
                    end
                    acc_a = '0; ka = 0; done_a++;
                end else begin
                    ka++;
                end
            end
            if (g == 0 && ovb && r) begin
                acc_b = (acc_b << 5) | 32'(odb);
                check("rand_msb_last_flag", {31'd0, olb}, {31'd0, (kb == 4)});
                if (kb == 4) begin
                    if (qb.size() == 0) begin
                        check("rand_msb_underflow", 32'd1, 32'd0);
                    end else begin
                        expw = qb.pop_front();
                        check("rand_msb_word", acc_b, expw);
                    end
                    acc_b = '0; kb = 0; done_b++;
                end else begin
                    kb++;
                end
            end
            stall   = ov && !r;
            prev_od = od;
            prev_ol = ol;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check($sformatf("rand%0d_words_done", g), 32'(done_a), 32'(nwords));
        check($sformatf("rand%0d_leftover", g), 32'(qa.size()), 32'd0);
        if (g == 0) check("rand_msb_words_done", 32'(done_b), 32'(nwords));
        $display("random group %0d: %0d words in %0d cycles", g, done_a, cycles);
    endtask

    vec_t vecs[9];
    vec_t v_rst;
    logic [4:0] b2b_exp [10];
    logic [4:0] bp_tail [3];

    initial begin
        vecs[0] = '{word: 23'h123456, msb: 1'b0, exp: {5'h16, 5'h02, 5'h0D, 5'h04, 5'h01}};
        vecs[1] = '{word: 23'h123456, msb: 1'b1, exp: {5'h01, 5'h04, 5'h0D, 5'h02, 5'h16}};
        vecs[2] = '{word: 23'h7FFFFF, msb: 1'b0, exp: {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h07}};
        vecs[3] = '{word: 23'h7FFFFF, msb: 1'b1, exp: {5'h07, 5'h1F, 5'h1F, 5'h1F, 5'h1F}};
        vecs[4] = '{word: 23'h000001, msb: 1'b0, exp: {5'h01, 5'h00, 5'h00, 5'h00, 5'h00}};
        vecs[5] = '{word: 23'h000001, msb: 1'b1, exp: {5'h00, 5'h00, 5'h00, 5'h00, 5'h01}};
        vecs[6] = '{word: 23'h555555, msb: 1'b0, exp: {5'h15, 5'h0A, 5'h15, 5'h0A, 5'h05}};
        vecs[7] = '{word: 23'h555555, msb: 1'b1, exp: {5'h05, 5'h0A, 5'h15, 5'h0A, 5'h15}};
        vecs[8] = '{word: 23'h000000, msb: 1'b0, exp: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
        v_rst   = '{word: 23'h000020, msb: 1'b0, exp: {5'h00, 5'h01, 5'h00, 5'h00, 5'h00}};
        b2b_exp = '{5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h07};
        bp_tail = '{5'h0D, 5'h04, 5'h01};

        rst = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0; data_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; data_b = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {25'd0, ov0, ol0, od0}, 32'd0);
        check("reset_outputs_msb", {25'd0, ov1, ol1, od1}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release_ready", {29'd0, ir0, ir1, ir2}, 32'h7);
        check("reset_release_valid", {29'd0, ov0, ov1, ov2}, 32'd0);

        // table-driven single words
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // back-to-back words with in_valid held: ten valid cycles in a row,
        // in_ready only in idle and on each last chunk
        @(negedge clk);
        in_valid_a = 1'b1; data_a = 23'h000001; out_ready_a = 1'b1;
        #1;
        check("b2b_idle_ready", {31'd0, ir0}, 32'd1);
        @(negedge clk);
        data_a = 23'h7FFFFF;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) begin in_valid_a = 1'b0; data_a = 23'h2AAAAA; end
            #1;
            check($sformatf("b2b_cycle%0d", i), {24'd0, ov0, ol0, ir0, od0},
                  {24'd0, 1'b1, (i % 5 == 4), (i % 5 == 4), b2b_exp[i]});
        end
        @(negedge clk);
        #1;
        check("b2b_back_idle", {31'd0, ov0}, 32'd0);
        $display("b2b: 0x000001 then 0x7FFFFF sent");

        // backpressure on the second chunk of 0x123456
        @(negedge clk);
        in_valid_a = 1'b1; data_a = 23'h123456; out_ready_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        #1;
        check("bp_chunk0", {26'd0, ov0, od0}, {26'd0, 1'b1, 5'h16});
        @(negedge clk);
        out_ready_a = 1'b0; data_a = 23'h7FFFFF;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            check($sformatf("bp_hold%0d", s), {24'd0, ov0, ol0, ir0, od0},
                  {24'd0, 1'b1, 1'b0, 1'b0, 5'h02});
        end
        @(negedge clk);
        out_ready_a = 1'b1;
        #1;
        check("bp_release", {24'd0, ov0, ol0, ir0, od0}, {24'd0, 1'b1, 1'b0, 1'b0, 5'h02});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_resume%0d", k), {25'd0, ov0, ol0, od0},
                  {25'd0, 1'b1, (k == 2), bp_tail[k]});
        end
        @(negedge clk);
        #1;
        check("bp_back_idle", {31'd0, ov0}, 32'd0);
        $display("backpressure: 0x123456 sent with 3-cycle stall");

        // reset pulsed mid-word, after the second chunk is taken
        @(negedge clk);
        in_valid_a = 1'b1; data_a = 23'h123456; out_ready_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_pre_chunk2", {26'd0, ov0, od0}, {26'd0, 1'b1, 5'h0D});
        rst = 1'b1;
        #1;
        check("rst_async_clear", {25'd0, ov0, ol0, od0}, 32'd0);
        check("rst_async_clear_msb", {25'd0, ov1, ol1, od1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release", {30'd0, ir0, ov0}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        #1;
        check("rst_no_residual", {31'd0, ov0}, 32'd0);
        $display("reset: word in flight discarded");
        run_vec(v_rst, 9);

        // random traffic
        rand_run(0, 300);
        rand_run(1, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
